// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four lane requesters, the arbiter and the downstream sink.
interface mux_rr_arbiter_if #(
   parameter int WIDTH = 4
);
   logic [3:0]       req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [3:0]       ack;
   logic [3:0]       grant;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             timeout;

   modport master (
      output req, a, b, c, d, out_ready,
      input  ack, grant, sel, out_data, out_valid, timeout
   );

   modport slave (
      input  req, a, b, c, d, out_ready,
      output ack, grant, sel, out_data, out_valid, timeout
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4-to-1 lane mux with registered output word,
// valid/ready handoff and optional stall timeout.
//
// state | meaning
// IDLE  | no word held; arbitrate from ptr when any req is high
// BUSY  | out_data holds an unconsumed word owned by lane sel
module mux_rr_arbiter #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 0
) (
   input logic              clk,
   input logic              rst,
   mux_rr_arbiter_if.slave  bus
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       sel_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic [3:0]       grant_q;
   logic [3:0]       ack_q;
   logic             timeout_q;
   logic [CW-1:0]    cnt;

   logic [1:0]       arb_base;
   logic [1:0]       win;
   logic [WIDTH-1:0] lane_mux;
   logic             do_load;

   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] idx;
      pick = base;
      // scan farthest-first so the nearest requester after base wins
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   always_comb begin
      arb_base = (state == BUSY) ? sel_q + 2'd1 : ptr;
      win      = pick(bus.req, arb_base);
      case (win)
         2'd0:    lane_mux = bus.a;
         2'd1:    lane_mux = bus.b;
         2'd2:    lane_mux = bus.c;
         default: lane_mux = bus.d;
      endcase
      do_load = (|bus.req) && ((state == IDLE) || bus.out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         sel_q     <= 2'd0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         grant_q   <= 4'b0;
         ack_q     <= 4'b0;
         timeout_q <= 1'b0;
         cnt       <= '0;
      end else begin
         ack_q     <= 4'b0;
         timeout_q <= 1'b0;
         if (state == BUSY && bus.out_ready) ptr <= sel_q + 2'd1;
         if (do_load) begin
            sel_q   <= win;
            data_q  <= lane_mux;
            valid_q <= 1'b1;
            grant_q <= 4'(1) << win;
            ack_q   <= 4'(1) << win;
            cnt     <= '0;
            state   <= BUSY;
         end else if (state == BUSY) begin
            if (bus.out_ready) begin
               valid_q <= 1'b0;
               grant_q <= 4'b0;
               cnt     <= '0;
               state   <= IDLE;
            end else if (TIMEOUT > 0) begin
               if (cnt == CNT_LAST) begin
                  valid_q   <= 1'b0;
                  grant_q   <= 4'b0;
                  timeout_q <= 1'b1;
                  ptr       <= sel_q + 2'd1;
                  cnt       <= '0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         end
      end
   end

   assign bus.ack       = ack_q;
   assign bus.grant     = grant_q;
   assign bus.sel       = sel_q;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: one arbiter with timeout disabled, one with TIMEOUT=3.
module tb_mux_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter_if #(.WIDTH(4)) ifa ();
   mux_rr_arbiter_if #(.WIDTH(4)) ift ();

   mux_rr_arbiter #(.WIDTH(4), .TIMEOUT(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mux_rr_arbiter #(.WIDTH(4), .TIMEOUT(3)) dut_t (.clk(clk), .rst(rst), .bus(ift));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rr_exp [5];
      rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000;
      rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010;

      ifa.req = 4'b0; ifa.a = 4'h0; ifa.b = 4'h0; ifa.c = 4'h0; ifa.d = 4'h0; ifa.out_ready = 1'b0;
      ift.req = 4'b0; ift.a = 4'h0; ift.b = 4'h0; ift.c = 4'h0; ift.d = 4'h0; ift.out_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_grant", 32'(ifa.grant), 32'd0);
      chk("rst_ack", 32'(ifa.ack), 32'd0);
      chk("rst_data", 32'(ifa.out_data), 32'd0);
      chk("rst_sel", 32'(ifa.sel), 32'd0);
      chk("rst_timeout", 32'(ift.timeout), 32'd0);
      tick(); tick();
      rst = 1'b0;

      // single request on lane b
      ifa.req = 4'b0010; ifa.b = 4'b0010;
      tick();
      chk("t1_ack", 32'(ifa.ack), 32'b0010);
      chk("t1_sel", 32'(ifa.sel), 32'd1);
      chk("t1_data", 32'(ifa.out_data), 32'b0010);
      chk("t1_valid", 32'(ifa.out_valid), 32'd1);
      chk("t1_grant", 32'(ifa.grant), 32'b0010);
      ifa.req = 4'b0; ifa.out_ready = 1'b1;
      tick();
      chk("t1_idle_valid", 32'(ifa.out_valid), 32'd0);
      chk("t1_idle_grant", 32'(ifa.grant), 32'd0);
      chk("t1_idle_sel", 32'(ifa.sel), 32'd1);
      chk("t1_idle_ack", 32'(ifa.ack), 32'd0);

      // ptr is now 2: c beats a
      ifa.req = 4'b0101; ifa.a = 4'h1; ifa.c = 4'h5;
      tick();
      chk("ptr2_grant", 32'(ifa.grant), 32'b0100);
      chk("ptr2_data", 32'(ifa.out_data), 32'h5);
      ifa.req = 4'b0;
      tick();
      chk("ptr2_idle", 32'(ifa.out_valid), 32'd0);

      // ptr is now 3: d then a back-to-back
      ifa.req = 4'b1001; ifa.a = 4'h3; ifa.d = 4'h9;
      tick();
      chk("wrap_d_grant", 32'(ifa.grant), 32'b1000);
      chk("wrap_d_ack", 32'(ifa.ack), 32'b1000);
      chk("wrap_d_data", 32'(ifa.out_data), 32'h9);
      ifa.req = 4'b0001;
      tick();
      chk("wrap_a_grant", 32'(ifa.grant), 32'b0001);
      chk("wrap_a_ack", 32'(ifa.ack), 32'b0001);
      chk("wrap_a_valid", 32'(ifa.out_valid), 32'd1);
      chk("wrap_a_data", 32'(ifa.out_data), 32'h3);
      ifa.req = 4'b0;
      tick();
      chk("wrap_idle", 32'(ifa.out_valid), 32'd0);

      // round robin with all requests held; ptr=1 so b goes first
      ifa.req = 4'b1111; ifa.a = 4'hA; ifa.b = 4'hB; ifa.c = 4'hC; ifa.d = 4'hD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rr_grant%0d", i), 32'(ifa.grant), 32'(rr_exp[i]));
         chk($sformatf("rr_ack%0d", i), 32'(ifa.ack), 32'(rr_exp[i]));
         chk($sformatf("rr_valid%0d", i), 32'(ifa.out_valid), 32'd1);
      end
      ifa.req = 4'b0;
      tick();
      chk("rr_idle", 32'(ifa.out_valid), 32'd0);

      // stall on lane c without timeout
      ifa.req = 4'b0100; ifa.c = 4'b0001; ifa.out_ready = 1'b0;
      tick();
      chk("st_load_grant", 32'(ifa.grant), 32'b0100);
      ifa.req = 4'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("st_data%0d", i), 32'(ifa.out_data), 32'b0001);
         chk($sformatf("st_grant%0d", i), 32'(ifa.grant), 32'b0100);
         chk($sformatf("st_ack%0d", i), 32'(ifa.ack), 32'd0);
         chk($sformatf("st_to%0d", i), 32'(ifa.timeout), 32'd0);
      end
      ifa.out_ready = 1'b1;
      tick();
      chk("st_accept", 32'(ifa.out_valid), 32'd0);
      ifa.out_ready = 1'b0;

      // timeout on the TIMEOUT=3 instance
      ift.req = 4'b0001; ift.a = 4'h6;
      tick();
      chk("to_valid0", 32'(ift.out_valid), 32'd1);
      chk("to_pulse0", 32'(ift.timeout), 32'd0);
      ift.req = 4'b0;
      tick();
      chk("to_pulse1", 32'(ift.timeout), 32'd0);
      tick();
      chk("to_pulse2", 32'(ift.timeout), 32'd0);
      chk("to_valid2", 32'(ift.out_valid), 32'd1);
      tick();
      chk("to_pulse3", 32'(ift.timeout), 32'd1);
      chk("to_valid3", 32'(ift.out_valid), 32'd0);
      chk("to_grant3", 32'(ift.grant), 32'd0);
      chk("to_ack3", 32'(ift.ack), 32'd0);
      ift.req = 4'b0011; ift.b = 4'h2;
      tick();
      chk("to_pulse_end", 32'(ift.timeout), 32'd0);
      chk("to_next_b", 32'(ift.grant), 32'b0010);
      ift.req = 4'b0; ift.out_ready = 1'b1;
      tick();
      chk("to_idle", 32'(ift.out_valid), 32'd0);

      // asynchronous reset while a word is held (ptr is 3 before reset)
      ifa.req = 4'b0001; ifa.a = 4'h7;
      tick();
      chk("rr6_loaded", 32'(ifa.out_valid), 32'd1);
      ifa.req = 4'b0;
      #2 rst = 1'b1;
      #1;
      chk("rr6_valid", 32'(ifa.out_valid), 32'd0);
      chk("rr6_grant", 32'(ifa.grant), 32'd0);
      chk("rr6_ack", 32'(ifa.ack), 32'd0);
      chk("rr6_data", 32'(ifa.out_data), 32'd0);
      tick();
      rst = 1'b0;
      ifa.req = 4'b1001; ifa.a = 4'h4; ifa.d = 4'h8;
      tick();
      chk("rr6_ptr0_grant", 32'(ifa.grant), 32'b0001);
      chk("rr6_ptr0_data", 32'(ifa.out_data), 32'h4);
      ifa.req = 4'b0; ifa.out_ready = 1'b1;
      tick();
      chk("rr6_idle", 32'(ifa.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
